// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI register-file peripheral: frame layout
// helpers (field positions derived from the address/data widths) and the
// encoding of the R/W bit.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

    // R/W bit encoding (first bit on the wire)
    localparam logic SPI_WRITE = 1'b1;
    localparam logic SPI_READ  = 1'b0;

    // Data field always occupies the least significant bits of the frame
    localparam int DATA_LSB = 0;

    // Total frame length: R/W bit + address field + data field
    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Bit position of the R/W flag inside a complete frame
    function automatic int rw_bit_pos(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    // Least significant bit of the address field inside a complete frame
    function automatic int addr_lsb_pos(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Single-bit multi-flop synchroniser with asynchronous reset to RST_VAL.
// The oldest TAPS stages are exported so the caller can detect edges on the
// last two synchronised stages without adding another flop.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input
//   q      out  [TAPS-1:0]; q[TAPS-1] = last stage, q[0] = newest exported stage
// -----------------------------------------------------------------------------
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter int   TAPS    = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            d,
    output logic [TAPS-1:0] q
);

    logic [STAGES-1:0] ff_r;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_r <= {STAGES{RST_VAL}};
        end else begin
            ff_r <= {ff_r[STAGES-2:0], d};
        end
    end

    assign q = ff_r[STAGES-1 -: TAPS];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// -----------------------------------------------------------------------------
// spi_regfile_peripheral
// SPI mode-0 peripheral giving read/write access to a NUM_REGS x DATA_W
// register file. Frame = R/W bit, ADDR_W address bits, DATA_W data bits,
// MSB first. Writes commit one clock after the synchronised nCS rise; reads
// shift the addressed register out on CIPO during the data phase.
// Ports:
//   clk        in   system clock (>= 8x SCLK)
//   rst_n      in   asynchronous active-low reset
//   nCS        in   chip select, active low, asynchronous
//   SCLK       in   SPI clock, idle low, asynchronous
//   COPI       in   controller-out data
//   CIPO       out  peripheral-out data
//   cipo_oe    out  CIPO output enable, high while a frame is active
//   regs_out   out  flattened register file, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse   out  one-clock pulse on a committed write
//   wr_addr    out  address of the last committed write
//   frame_err  out  one-clock pulse on an aborted or over-long frame
// -----------------------------------------------------------------------------
module spi_regfile_peripheral
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_W  = frame_width(ADDR_W, DATA_W);
    localparam int RW_BIT   = rw_bit_pos(ADDR_W, DATA_W);
    localparam int ADDR_LSB = addr_lsb_pos(DATA_W);
    localparam int CNT_W    = $clog2(FRAME_W + 1);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [CNT_W-1:0]  FRAME_CNT  = CNT_W'(FRAME_W);
    // Count value just before the last address bit arrives
    localparam logic [CNT_W-1:0]  LOAD_PRE   = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    // Synchronised inputs: [1] = last stage, [0] = stage before it
    logic [1:0] ncs_sync_s;
    logic [1:0] sclk_sync_s;
    logic [0:0] copi_sync_s;

    logic ncs_fall_s, ncs_rise_s, ncs_low_s;
    logic sclk_rise_s, sclk_fall_s;

    logic [FRAME_W-1:0] rx_r;
    logic [FRAME_W-1:0] rx_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               overrun_r;
    logic               commit_r;
    logic [DATA_W-1:0]  tx_r;
    logic [DATA_W-1:0]  regs_r [NUM_REGS];

    logic               ld_rw_s;
    logic [ADDR_W-1:0]  ld_addr_s;
    logic [DATA_W-1:0]  ld_data_s;
    logic               cm_rw_s;
    logic [ADDR_W-1:0]  cm_addr_s;
    logic [DATA_W-1:0]  cm_data_s;
    logic               cm_in_range_s;

    spi_sync #(.STAGES(SYNC_STAGES), .TAPS(2), .RST_VAL(1'b1)) u_sync_ncs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (nCS),
        .q     (ncs_sync_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .TAPS(2), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (SCLK),
        .q     (sclk_sync_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .TAPS(1), .RST_VAL(1'b0)) u_sync_copi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (COPI),
        .q     (copi_sync_s)
    );

    // Edge detection on the last two synchronised stages
    always_comb begin
        ncs_fall_s  = ncs_sync_s[1] & ~ncs_sync_s[0];
        ncs_rise_s  = ~ncs_sync_s[1] & ncs_sync_s[0];
        ncs_low_s   = ~ncs_sync_s[0];
        sclk_rise_s = ~sclk_sync_s[1] & sclk_sync_s[0];
        sclk_fall_s = sclk_sync_s[1] & ~sclk_sync_s[0];
    end

    // Decode the frame being shifted in (read load) and the completed frame (commit)
    always_comb begin
        rx_next_s = {rx_r[FRAME_W-2:0], copi_sync_s[0]};
        // R/W and address sit in the low bits at the moment the last address bit lands
        ld_rw_s   = rx_next_s[ADDR_W];
        ld_addr_s = rx_next_s[ADDR_W-1:0];
        if ({1'b0, ld_addr_s} < NUM_REGS_L) begin
            ld_data_s = regs_r[ld_addr_s[IDX_W-1:0]];
        end else begin
            ld_data_s = {DATA_W{1'b0}};
        end
        cm_rw_s       = rx_r[RW_BIT];
        cm_addr_s     = rx_r[ADDR_LSB +: ADDR_W];
        cm_data_s     = rx_r[DATA_LSB +: DATA_W];
        cm_in_range_s = ({1'b0, cm_addr_s} < NUM_REGS_L);
    end

    // Frame reception, read-back shifting and end-of-frame commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_r      <= {FRAME_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            overrun_r <= 1'b0;
            commit_r  <= 1'b0;
            tx_r      <= {DATA_W{1'b0}};
            CIPO      <= 1'b0;
            cipo_oe   <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= {ADDR_W{1'b0}};
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;

            // Evaluated one clock after the nCS rise; a new frame start below overrides cipo_oe
            if (commit_r) begin
                commit_r <= 1'b0;
                cipo_oe  <= 1'b0;
                CIPO     <= 1'b0;
                tx_r     <= {DATA_W{1'b0}};
                if ((cnt_r == FRAME_CNT) && !overrun_r) begin
                    if ((cm_rw_s == SPI_WRITE) && cm_in_range_s) begin
                        regs_r[cm_addr_s[IDX_W-1:0]] <= cm_data_s;
                        wr_addr  <= cm_addr_s;
                        wr_pulse <= 1'b1;
                    end
                end else begin
                    frame_err <= 1'b1;
                end
            end

            if (ncs_fall_s) begin
                // Frame start wins over any SCLK edge seen in the same cycle
                cnt_r     <= {CNT_W{1'b0}};
                rx_r      <= {FRAME_W{1'b0}};
                overrun_r <= 1'b0;
                tx_r      <= {DATA_W{1'b0}};
                CIPO      <= 1'b0;
                cipo_oe   <= 1'b1;
            end else if (ncs_rise_s) begin
                commit_r <= 1'b1;
            end else if (ncs_low_s) begin
                if (sclk_rise_s) begin
                    if (cnt_r < FRAME_CNT) begin
                        rx_r  <= rx_next_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if ((cnt_r == LOAD_PRE) && (ld_rw_s == SPI_READ)) begin
                            tx_r <= ld_data_s;
                        end
                    end else begin
                        overrun_r <= 1'b1;
                    end
                end else if (sclk_fall_s) begin
                    // tx_r drains to zero, so CIPO returns low after the last data bit
                    CIPO <= tx_r[DATA_W-1];
                    tx_r <= {tx_r[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[g*DATA_W +: DATA_W] = regs_r[g];
    end

endmodule
